// File: rtl/asteroids_pkg.sv
// rtl/asteroids_pkg.sv - shared screen geometry, colour constants and draw scheduler state type
package asteroids_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  localparam logic [X_W:0] X_LIMIT = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] Y_LIMIT = SCREEN_H[Y_W:0];

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    FINISH
  } draw_state_t;

  // Coordinates carry one extra bit so a sprite hanging off the right/bottom edge is clipped, not wrapped.
  function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < X_LIMIT) && (y < Y_LIMIT);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - frame rate down-counter producing the shared one-cycle frame_tick
module frame_timer #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick,
  output logic at_zero
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] count;

  // at_zero marks the edge on which the tick is registered and the scheduler may start a pass.
  assign at_zero = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= RELOAD;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= at_zero;
      count      <= at_zero ? RELOAD : count - 1'b1;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - per-frame owner of the VGA write port: erases then redraws each object's sprite
module draw_scheduler
  import asteroids_pkg::*;
#(
  parameter int N_OBJ     = 4,
  parameter int SPRITE_W  = 4,
  parameter int FRAME_DIV = 833333
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [X_W*N_OBJ-1:0]      obj_x,
  input  logic [Y_W*N_OBJ-1:0]      obj_y,
  input  logic [COLOUR_W*N_OBJ-1:0] obj_colour,
  input  logic [N_OBJ-1:0]          obj_en,
  output logic                      frame_tick,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_overrun
);

  localparam int I_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int D_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int S_W  = I_W + 2;
  localparam int XP_W = X_W + 1;
  localparam int YP_W = Y_W + 1;
  localparam logic [D_W-1:0] D_LAST = D_W'(SPRITE_W - 1);

  draw_state_t      state, state_n;
  logic [I_W-1:0]   idx, idx_n;
  logic [D_W-1:0]   dx, dx_n, dy, dy_n;

  logic [X_W-1:0]      new_x [N_OBJ];
  logic [Y_W-1:0]      new_y [N_OBJ];
  logic [COLOUR_W-1:0] new_colour [N_OBJ];
  logic [N_OBJ-1:0]    new_en;
  logic [X_W-1:0]      old_x [N_OBJ];
  logic [Y_W-1:0]      old_y [N_OBJ];
  logic [N_OBJ-1:0]    old_en;

  logic at_zero;
  logic start, emit, finish;

  frame_timer #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .at_zero    (at_zero)
  );

  // Phase sequence is 2*i for erase and 2*i+1 for draw; the scan finds the next enabled phase so
  // disabled phases cost no cycles. On the snapshot edge the new set is still on the inputs.
  logic [S_W-1:0]   scan_from;
  logic [N_OBJ-1:0] scan_new_en;

  always_comb begin
    scan_from   = (state == IDLE) ? '0 : {1'b0, idx, state == DRAW} + 1'b1;
    scan_new_en = (state == IDLE) ? obj_en : new_en;
  end

  logic           scan_found, scan_draw;
  logic [I_W-1:0] scan_idx;
  draw_state_t    scan_state;

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_draw  = 1'b0;
    scan_state = FINISH;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (scan_new_en[i] && (S_W'(2 * i + 1) >= scan_from)) begin
        scan_found = 1'b1;
        scan_idx   = I_W'(i);
        scan_draw  = 1'b1;
      end
      if (old_en[i] && (S_W'(2 * i) >= scan_from)) begin
        scan_found = 1'b1;
        scan_idx   = I_W'(i);
        scan_draw  = 1'b0;
      end
    end
    if (scan_found) begin
      scan_state = scan_draw ? DRAW : ERASE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      dx    <= '0;
      dy    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dx    <= dx_n;
      dy    <= dy_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dx_n    = dx;
    dy_n    = dy;
    start   = 1'b0;
    emit    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (at_zero) begin
          start   = 1'b1;
          dx_n    = '0;
          dy_n    = '0;
          idx_n   = scan_idx;
          state_n = scan_state;
        end
      end
      ERASE, DRAW: begin
        emit = 1'b1;
        if (dx != D_LAST) begin
          dx_n = dx + 1'b1;
        end else begin
          dx_n = '0;
          if (dy != D_LAST) begin
            dy_n = dy + 1'b1;
          end else begin
            dy_n    = '0;
            idx_n   = scan_idx;
            state_n = scan_state;
          end
        end
      end
      FINISH: begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [X_W-1:0]  base_x;
  logic [Y_W-1:0]  base_y;
  logic [X_W:0]    pix_x;
  logic [Y_W:0]    pix_y;

  always_comb begin
    base_x = (state == DRAW) ? new_x[idx] : old_x[idx];
    base_y = (state == DRAW) ? new_y[idx] : old_y[idx];
    pix_x  = {1'b0, base_x} + XP_W'(dx);
    pix_y  = {1'b0, base_y} + YP_W'(dy);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x         <= '0;
      vga_y         <= '0;
      vga_colour    <= '0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      new_en        <= '0;
      old_en        <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        new_x[i]      <= '0;
        new_y[i]      <= '0;
        new_colour[i] <= '0;
        old_x[i]      <= '0;
        old_y[i]      <= '0;
      end
    end else begin
      plot          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= at_zero && (state != IDLE);
      if (start) begin
        busy   <= 1'b1;
        new_en <= obj_en;
        for (int i = 0; i < N_OBJ; i++) begin
          new_x[i]      <= obj_x[X_W*i +: X_W];
          new_y[i]      <= obj_y[Y_W*i +: Y_W];
          new_colour[i] <= obj_colour[COLOUR_W*i +: COLOUR_W];
        end
      end
      if (emit) begin
        vga_x      <= pix_x[X_W-1:0];
        vga_y      <= pix_y[Y_W-1:0];
        vga_colour <= (state == DRAW) ? new_colour[idx] : COLOUR_BLACK;
        plot       <= on_screen(pix_x, pix_y);
      end
      if (finish) begin
        busy       <= 1'b0;
        frame_done <= 1'b1;
        old_en     <= new_en;
        for (int i = 0; i < N_OBJ; i++) begin
          old_x[i] <= new_x[i];
          old_y[i] <= new_y[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - scoreboard bench for draw_scheduler against a frame-level reference model
`timescale 1ns/1ps
module tb_draw_scheduler;

  localparam int N_OBJ    = 2;
  localparam int SPRITE_W = 2;
  localparam int FD_A     = 100;
  localparam int FD_B     = 6;

  typedef struct { int e; int x; int y; int c; } pix_t;
  typedef struct { int done_e; int busy_len; } pass_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [15:0] x_a = '0, x_b = '0;
  logic [13:0] y_a = '0, y_b = '0;
  logic [5:0]  c_a = '0, c_b = '0;
  logic [1:0]  en_a = '0, en_b = '0;

  logic       tick_a, plot_a, busy_a, done_a, ovr_a;
  logic [7:0] vx_a;
  logic [6:0] vy_a;
  logic [2:0] vc_a;
  logic       tick_b, plot_b, busy_b, done_b, ovr_b;
  logic [7:0] vx_b;
  logic [6:0] vy_b;
  logic [2:0] vc_b;

  draw_scheduler #(.N_OBJ(N_OBJ), .SPRITE_W(SPRITE_W), .FRAME_DIV(FD_A)) dut_a (
    .clk(clk), .reset(reset), .obj_x(x_a), .obj_y(y_a), .obj_colour(c_a), .obj_en(en_a),
    .frame_tick(tick_a), .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a), .plot(plot_a),
    .busy(busy_a), .frame_done(done_a), .frame_overrun(ovr_a)
  );

  draw_scheduler #(.N_OBJ(N_OBJ), .SPRITE_W(SPRITE_W), .FRAME_DIV(FD_B)) dut_b (
    .clk(clk), .reset(reset), .obj_x(x_b), .obj_y(y_b), .obj_colour(c_b), .obj_en(en_b),
    .frame_tick(tick_b), .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b), .plot(plot_b),
    .busy(busy_b), .frame_done(done_b), .frame_overrun(ovr_b)
  );

  always #5 clk = ~clk;

  // Edge index: the first edge after reset release is edge 0, so after edge e ecount == e+1.
  int ecount = 0;
  always @(posedge clk) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  pix_t  pixq  [2][$];
  pass_t passq [2][$];
  int    tickq [2][$];
  int    ovrq  [2][$];
  int    m_fin [2] = '{-1, -1};
  bit    m_old_en [2][N_OBJ];
  int    m_old_x  [2][N_OBJ];
  int    m_old_y  [2][N_OBJ];
  int    busy_run [2] = '{0, 0};

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic int in_x(input int inst, input int i);
    logic [15:0] v;
    v = (inst == 0) ? x_a : x_b;
    return int'(v[8*i +: 8]);
  endfunction

  function automatic int in_y(input int inst, input int i);
    logic [13:0] v;
    v = (inst == 0) ? y_a : y_b;
    return int'(v[7*i +: 7]);
  endfunction

  function automatic int in_c(input int inst, input int i);
    logic [5:0] v;
    v = (inst == 0) ? c_a : c_b;
    return int'(v[3*i +: 3]);
  endfunction

  function automatic bit in_en(input int inst, input int i);
    logic [1:0] v;
    v = (inst == 0) ? en_a : en_b;
    return v[i];
  endfunction

  task automatic add_pixel(input int inst, input int e, input int x, input int y, input int c);
    pix_t p;
    if (x < 160 && y < 120) begin
      p.e = e; p.x = x; p.y = y; p.c = c;
      pixq[inst].push_back(p);
    end
  endtask

  // Reference: a whole pass is the list of sprite squares (erase old, draw new per object),
  // one pixel slot per cycle starting the edge after the tick, then one finishing edge.
  task automatic model_tick(input int inst, input int e0);
    int    k;
    int    nx [N_OBJ];
    int    ny [N_OBJ];
    int    nc [N_OBJ];
    bit    nen [N_OBJ];
    pass_t ps;
    tickq[inst].push_back(e0);
    if (e0 <= m_fin[inst]) begin
      ovrq[inst].push_back(e0);
      return;
    end
    for (int i = 0; i < N_OBJ; i++) begin
      nx[i] = in_x(inst, i); ny[i] = in_y(inst, i); nc[i] = in_c(inst, i); nen[i] = in_en(inst, i);
    end
    k = 0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (m_old_en[inst][i])
        for (int dy = 0; dy < SPRITE_W; dy++)
          for (int dx = 0; dx < SPRITE_W; dx++) begin
            add_pixel(inst, e0 + k + 1, m_old_x[inst][i] + dx, m_old_y[inst][i] + dy, 0);
            k++;
          end
      if (nen[i])
        for (int dy = 0; dy < SPRITE_W; dy++)
          for (int dx = 0; dx < SPRITE_W; dx++) begin
            add_pixel(inst, e0 + k + 1, nx[i] + dx, ny[i] + dy, nc[i]);
            k++;
          end
    end
    ps.done_e   = e0 + k + 1;
    ps.busy_len = k + 1;
    passq[inst].push_back(ps);
    m_fin[inst] = e0 + k + 1;
    for (int i = 0; i < N_OBJ; i++) begin
      m_old_en[inst][i] = nen[i]; m_old_x[inst][i] = nx[i]; m_old_y[inst][i] = ny[i];
    end
  endtask

  task automatic monitor(input int inst, input int e, input logic tick, input logic ovr,
                         input logic plot, input logic busy, input logic done,
                         input logic [7:0] vx, input logic [6:0] vy, input logic [2:0] vc);
    pix_t  p;
    pass_t ps;
    int    t;
    if (tick) begin
      if (tickq[inst].size() == 0) check($sformatf("tick_%0d", inst), 1'b0, $sformatf("pulse at edge %0d, none expected", e));
      else begin
        t = tickq[inst].pop_front();
        check($sformatf("tick_%0d", inst), e == t, $sformatf("pulse at edge %0d, expected edge %0d", e, t));
      end
    end
    if (ovr) begin
      if (ovrq[inst].size() == 0) check($sformatf("overrun_%0d", inst), 1'b0, $sformatf("pulse at edge %0d, none expected", e));
      else begin
        t = ovrq[inst].pop_front();
        check($sformatf("overrun_%0d", inst), e == t, $sformatf("pulse at edge %0d, expected edge %0d", e, t));
      end
    end
    if (plot) begin
      if (pixq[inst].size() == 0)
        check($sformatf("pixel_%0d", inst), 1'b0, $sformatf("plot at edge %0d (%0d,%0d) c=%0d, none expected", e, vx, vy, vc));
      else begin
        p = pixq[inst].pop_front();
        check($sformatf("pixel_%0d", inst), (e == p.e) && (int'(vx) == p.x) && (int'(vy) == p.y) && (int'(vc) == p.c),
              $sformatf("got edge %0d (%0d,%0d) c=%0d, expected edge %0d (%0d,%0d) c=%0d", e, vx, vy, vc, p.e, p.x, p.y, p.c));
      end
    end
    if (busy) busy_run[inst]++;
    if (done) begin
      if (passq[inst].size() == 0) check($sformatf("pass_%0d", inst), 1'b0, $sformatf("frame_done at edge %0d, none expected", e));
      else begin
        ps = passq[inst].pop_front();
        check($sformatf("pass_%0d", inst), (e == ps.done_e) && (busy_run[inst] == ps.busy_len) && !busy,
              $sformatf("done at edge %0d busy %0d cycles busy_now=%0b, expected edge %0d busy %0d cycles busy_now=0",
                        e, busy_run[inst], busy, ps.done_e, ps.busy_len));
      end
      busy_run[inst] = 0;
    end
  endtask

  task automatic check_drained(input int inst, input int e_last);
    int stale;
    stale = 0;
    for (int j = 0; j < pixq[inst].size(); j++)  if (pixq[inst][j].e <= e_last) stale++;
    for (int j = 0; j < passq[inst].size(); j++) if (passq[inst][j].done_e <= e_last) stale++;
    for (int j = 0; j < tickq[inst].size(); j++) if (tickq[inst][j] <= e_last) stale++;
    for (int j = 0; j < ovrq[inst].size(); j++)  if (ovrq[inst][j] <= e_last) stale++;
    check($sformatf("drained_%0d", inst), stale == 0, $sformatf("%0d expected events never seen, expected 0", stale));
  endtask

  task automatic flush_model();
    for (int inst = 0; inst < 2; inst++) begin
      pixq[inst].delete(); passq[inst].delete(); tickq[inst].delete(); ovrq[inst].delete();
      m_fin[inst] = -1;
      busy_run[inst] = 0;
      for (int i = 0; i < N_OBJ; i++) m_old_en[inst][i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ecount > 0) begin
        monitor(0, ecount - 1, tick_a, ovr_a, plot_a, busy_a, done_a, vx_a, vy_a, vc_a);
        monitor(1, ecount - 1, tick_b, ovr_b, plot_b, busy_b, done_b, vx_b, vy_b, vc_b);
      end
      if (ecount % FD_A == FD_A - 1) model_tick(0, ecount);
      if (ecount % FD_B == FD_B - 1) model_tick(1, ecount);
    end
  end

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (ecount < target && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("wait_edge", ecount >= target, $sformatf("edge count %0d, expected at least %0d", ecount, target));
  endtask

  task automatic randomize_a();
    for (int i = 0; i < N_OBJ; i++) begin
      x_a[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(150, 160));
      y_a[7*i +: 7] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(110, 120));
      c_a[3*i +: 3] = 3'($urandom_range(0, 7));
    end
    en_a = 2'($urandom_range(0, 3));
  endtask

  initial begin
    x_b = {8'd159, 8'd30}; y_b = {7'd118, 7'd40}; c_b = {3'd2, 3'd5}; en_b = 2'b11;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {tick_a, plot_a, busy_a, done_a, ovr_a, vx_a, vy_a, vc_a} == '0,
          $sformatf("tick=%0b plot=%0b busy=%0b done=%0b ovr=%0b x=%0d y=%0d c=%0d, expected all 0",
                    tick_a, plot_a, busy_a, done_a, ovr_a, vx_a, vy_a, vc_a));
    check("reset_b", {tick_b, plot_b, busy_b, done_b, ovr_b, vx_b, vy_b, vc_b} == '0,
          $sformatf("tick=%0b plot=%0b busy=%0b done=%0b ovr=%0b x=%0d y=%0d c=%0d, expected all 0",
                    tick_b, plot_b, busy_b, done_b, ovr_b, vx_b, vy_b, vc_b));
    reset = 1'b0;

    wait_edge(210);
    x_a = {8'd0, 8'd10}; y_a = {7'd0, 7'd20}; c_a = {3'd0, 3'b100}; en_a = 2'b01;
    wait_edge(310);
    x_a[7:0] = 8'd12;
    wait_edge(410);
    x_a[15:8] = 8'd159; y_a[13:7] = 7'd119; c_a[5:3] = 3'b011; en_a = 2'b11;

    wait_edge(510);
    while (ecount < 1210) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) randomize_a();
    end

    wait_edge(1250);
    x_a = {8'd70, 8'd40}; y_a = {7'd60, 7'd50}; c_a = {3'd1, 3'd6}; en_a = 2'b11;
    wait_edge(1303);
    check("busy_before_reset", busy_a == 1'b1, $sformatf("busy=%0b, expected 1", busy_a));
    reset = 1'b1;
    flush_model();
    #1;
    check("async_reset", {plot_a, busy_a, done_a, vx_a, vy_a, vc_a} == '0,
          $sformatf("plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d, expected all 0",
                    plot_a, busy_a, done_a, vx_a, vy_a, vc_a));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    wait_edge(260);
    @(negedge clk);
    #1;
    check_drained(0, ecount - 1);
    check_drained(1, ecount - 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
